ulpi_reg_arbiter: RTL and testbench
===================================

ULPI_REG_ARBITER -- requirements
Module: ulpi_reg_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 8'd200, max WAIT_RSP cycles before error.
REQ-002 Parameter MAX_RETRY, default 2, re-issues allowed after link abort.
REQ-003 i_clk  in  1  clock; all logic on rising edge.
REQ-004 i_rst  in  1  reset, synchronous, active-high.
REQ-005 i_req  in  2  per-requester request level, held until o_gnt.
REQ-006 i_we  in  2  per-requester write(1)/read(0).
REQ-007 i_addr  in  12  requester n register address at [6n+5:6n].
REQ-008 i_wdata  in  16  requester n write data at [8n+7:8n].
REQ-009 o_gnt  out  2  one-hot grant pulse; requester fields sampled that cycle.
REQ-010 o_done  out  2  one-hot completion pulse.
REQ-011 o_err  out  1  valid with o_done; 1 = timeout or retries exhausted.
REQ-012 o_rdata  out  8  read data, valid with o_done when read and o_err=0.
REQ-013 i_link_idle  in  1  ULPI link controller in idle state, dir low.
REQ-014 o_cmd_valid / i_cmd_ready  out/in  1/1  command handshake to link controller.
REQ-015 o_cmd_we, o_cmd_addr, o_cmd_wdata  out  1/6/8  command fields, stable while o_cmd_valid.
REQ-016 i_rsp_valid  in  1  one-cycle pulse: write acked or read data on i_rsp_data.
REQ-017 i_rsp_data  in  8  read data, qualified by i_rsp_valid.
REQ-018 i_rsp_abort  in  1  one-cycle pulse: PHY asserted dir mid-command, command lost.

Function
REQ-019 FSM states IDLE, GRANT, ISSUE, WAIT_RSP, DONE; exactly one active.
REQ-020 IDLE: if i_link_idle=1 and |i_req, the arbiter picks a winner and enters GRANT next edge; else stays IDLE.
REQ-021 Winner is round-robin: pointer rr (1 bit) names the preferred requester; if only one requests, it wins.
REQ-022 rr becomes the non-winning index on the IDLE->GRANT edge.
REQ-023 GRANT (1 cycle): o_gnt[winner]=1, we/addr/wdata of winner latched into the command register, retry count cleared; next state ISSUE.
REQ-024 A request deasserted before GRANT is never granted; no done is produced for it.
REQ-025 ISSUE: o_cmd_valid=1 with latched fields; on i_cmd_ready=1, WAIT_RSP next edge, timer cleared; o_cmd_valid low from that edge.
REQ-026 WAIT_RSP: 8-bit timer increments each cycle, saturating.
REQ-027 WAIT_RSP, i_rsp_valid=1: rdata <= i_rsp_data (reads only; writes keep 8'h00), err<=0, DONE next edge.
REQ-028 WAIT_RSP, i_rsp_abort=1, retries<MAX_RETRY: retries+1, back to ISSUE, same fields.
REQ-029 WAIT_RSP, i_rsp_abort=1, retries=MAX_RETRY: err<=1, DONE.
REQ-030 WAIT_RSP, timer=TIMEOUT_CYCLES-1 with no rsp/abort: err<=1, DONE.
REQ-031 Priority in same cycle: i_rsp_valid over i_rsp_abort over timeout.
REQ-032 i_rsp_valid/i_rsp_abort outside WAIT_RSP are ignored.
REQ-033 DONE (1 cycle): o_done[owner]=1, o_err, o_rdata driven; next IDLE; o_rdata holds until next DONE.
REQ-034 Minimum latency req->done with cmd_ready=1 and rsp next cycle: 5 cycles (IDLE, GRANT, ISSUE, WAIT_RSP, DONE).
REQ-035 At most one command outstanding; requests arriving during GRANT..DONE wait.
REQ-036 i_link_idle is only sampled in IDLE; deassertion later does not cancel a command.

Reset
REQ-037 i_rst=1: state IDLE, rr=0, retries=0, timer=0, command register 0, rdata=8'h00.
REQ-038 Reset outputs: o_gnt=0, o_done=0, o_err=0, o_rdata=0, o_cmd_valid=0, o_cmd_we=0, o_cmd_addr=0, o_cmd_wdata=0.
REQ-039 Reset mid-operation aborts silently: no o_done pulse for the in-flight requester; first post-reset cycle is IDLE.

Verification
REQ-040 Req0 write addr 6'h16 data 8'hFF, ready=1, rsp_valid 1 cycle after handshake -> o_gnt=01, cmd fields 1/16/FF, o_done=01, o_err=0 at cycle 5.
REQ-041 Both requests high from reset, continuous -> grants alternate 01,10,01,10; rr toggles each grant.
REQ-042 Req1 read 6'h00, rsp_data 8'h24 -> o_done=10, o_rdata=8'h24, o_err=0.
REQ-043 Abort pulsed 3 times with MAX_RETRY=2 -> 3 cmd handshakes, then o_done with o_err=1.
REQ-044 No response, TIMEOUT_CYCLES=200 -> o_done with o_err=1 exactly 200 cycles after entering WAIT_RSP; rsp_valid+abort same cycle -> success, no retry.
REQ-045 i_rst asserted in WAIT_RSP -> all outputs 0 next cycle, no o_done; i_link_idle=0 with req high -> no grant until it rises.

Source files
------------

// File: rtl/ulpi_reg_arbiter.sv
// ULPI register access arbiter: round-robin between two requesters with a
// single outstanding link command, abort retry and response timeout.
module ulpi_reg_arbiter #(
    parameter logic [7:0] TIMEOUT_CYCLES = 8'd200,
    parameter int         MAX_RETRY      = 2
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [1:0]  i_req,
    input  logic [1:0]  i_we,
    input  logic [11:0] i_addr,
    input  logic [15:0] i_wdata,
    output logic [1:0]  o_gnt,
    output logic [1:0]  o_done,
    output logic        o_err,
    output logic [7:0]  o_rdata,
    input  logic        i_link_idle,
    output logic        o_cmd_valid,
    input  logic        i_cmd_ready,
    output logic        o_cmd_we,
    output logic [5:0]  o_cmd_addr,
    output logic [7:0]  o_cmd_wdata,
    input  logic        i_rsp_valid,
    input  logic [7:0]  i_rsp_data,
    input  logic        i_rsp_abort
);

    localparam int RW = (MAX_RETRY < 2) ? 1 : $clog2(MAX_RETRY + 1);
    localparam logic [RW-1:0] RETRY_LIM = RW'(MAX_RETRY);
    localparam logic [7:0] TIMER_LAST = TIMEOUT_CYCLES - 8'd1;

    typedef enum logic [2:0] {
        IDLE,
        GRANT,
        ISSUE,
        WAIT_RSP,
        DONE
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic            rr;
    logic            owner;
    logic            win;
    logic            start;
    logic [RW-1:0]   retries;
    logic [7:0]      timer;
    logic            err;
    logic            can_retry;
    logic            timed_out;
    logic [1:0]      owner_oh;
    logic            cmd_we;
    logic [5:0]      cmd_addr;
    logic [7:0]      cmd_wdata;
    logic [7:0]      rdata;

    assign win       = (&i_req) ? rr : i_req[1];
    assign start     = i_link_idle && (|i_req);
    assign can_retry = retries < RETRY_LIM;
    assign timed_out = timer == TIMER_LAST;
    assign owner_oh  = owner ? 2'b10 : 2'b01;

    assign o_cmd_we    = cmd_we;
    assign o_cmd_addr  = cmd_addr;
    assign o_cmd_wdata = cmd_wdata;
    assign o_rdata     = rdata;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        o_gnt       = 2'b00;
        o_done      = 2'b00;
        o_err       = 1'b0;
        o_cmd_valid = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = GRANT;
                end
            end
            GRANT: begin
                o_gnt     = owner_oh;
                state_nxt = ISSUE;
            end
            ISSUE: begin
                o_cmd_valid = 1'b1;
                if (i_cmd_ready) begin
                    state_nxt = WAIT_RSP;
                end
            end
            WAIT_RSP: begin
                // Response wins over abort, abort wins over timeout.
                if (i_rsp_valid) begin
                    state_nxt = DONE;
                end else if (i_rsp_abort) begin
                    state_nxt = can_retry ? ISSUE : DONE;
                end else if (timed_out) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                o_done    = owner_oh;
                o_err     = err;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rr        <= 1'b0;
            owner     <= 1'b0;
            retries   <= '0;
            timer     <= 8'h00;
            err       <= 1'b0;
            cmd_we    <= 1'b0;
            cmd_addr  <= 6'h00;
            cmd_wdata <= 8'h00;
            rdata     <= 8'h00;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        owner <= win;
                        rr    <= ~win;
                    end
                end
                GRANT: begin
                    cmd_we    <= owner ? i_we[1] : i_we[0];
                    cmd_addr  <= owner ? i_addr[11:6] : i_addr[5:0];
                    cmd_wdata <= owner ? i_wdata[15:8] : i_wdata[7:0];
                    retries   <= '0;
                end
                ISSUE: begin
                    if (i_cmd_ready) begin
                        timer <= 8'h00;
                    end
                end
                WAIT_RSP: begin
                    if (timer != 8'hFF) begin
                        timer <= timer + 8'd1;
                    end
                    if (i_rsp_valid) begin
                        rdata <= cmd_we ? 8'h00 : i_rsp_data;
                        err   <= 1'b0;
                    end else if (i_rsp_abort) begin
                        if (can_retry) begin
                            retries <= retries + RW'(1);
                        end else begin
                            err <= 1'b1;
                        end
                    end else if (timed_out) begin
                        err <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ulpi_reg_arbiter.sv
// Directed bench for ulpi_reg_arbiter: scoreboard of expected completions,
// link controller behaviour scripted inline.
module tb_ulpi_reg_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req;
    logic [1:0]  we;
    logic [11:0] addr;
    logic [15:0] wdata;
    logic [1:0]  gnt;
    logic [1:0]  done;
    logic        err;
    logic [7:0]  rdata;
    logic        link_idle;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_we;
    logic [5:0]  cmd_addr;
    logic [7:0]  cmd_wdata;
    logic        rsp_valid;
    logic [7:0]  rsp_data;
    logic        rsp_abort;

    always #5 clk = ~clk;

    ulpi_reg_arbiter #(
        .TIMEOUT_CYCLES(8'd200),
        .MAX_RETRY(2)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .i_req(req),
        .i_we(we),
        .i_addr(addr),
        .i_wdata(wdata),
        .o_gnt(gnt),
        .o_done(done),
        .o_err(err),
        .o_rdata(rdata),
        .i_link_idle(link_idle),
        .o_cmd_valid(cmd_valid),
        .i_cmd_ready(cmd_ready),
        .o_cmd_we(cmd_we),
        .o_cmd_addr(cmd_addr),
        .o_cmd_wdata(cmd_wdata),
        .i_rsp_valid(rsp_valid),
        .i_rsp_data(rsp_data),
        .i_rsp_abort(rsp_abort)
    );

    typedef struct packed {
        logic [1:0] done;
        logic       err;
        logic       chk;
        logic [7:0] rdata;
    } exp_t;

    exp_t sb[$];
    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int hs = 0;
    int t0;
    int hs0;
    int w;

    logic [28:0] outs;
    assign outs = {gnt, done, err, rdata, cmd_valid, cmd_we, cmd_addr, cmd_wdata};

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
    endtask

    task automatic push(input logic [1:0] d, input logic e,
                        input logic c, input logic [7:0] r);
        exp_t x;
        x.done  = d;
        x.err   = e;
        x.chk   = c;
        x.rdata = r;
        sb.push_back(x);
    endtask

    task automatic set_fields(input int n, input logic w_, input logic [5:0] a,
                              input logic [7:0] d);
        if (n == 0) begin
            we[0]      = w_;
            addr[5:0]  = a;
            wdata[7:0] = d;
        end else begin
            we[1]       = w_;
            addr[11:6]  = a;
            wdata[15:8] = d;
        end
    endtask

    task automatic wait_gnt(input logic [1:0] exp, input bit drop);
        int n = 0;
        while (gnt === 2'b00 && n < 30) begin
            tick();
            n++;
        end
        check("gnt", gnt, exp);
        if (drop) req = req & ~exp;
    endtask

    task automatic do_cmd(input logic w_, input logic [5:0] a, input logic [7:0] d);
        int n = 0;
        while (cmd_valid !== 1'b1 && n < 30) begin
            tick();
            n++;
        end
        check("cmd_valid", cmd_valid, 1);
        check("cmd_we", cmd_we, w_);
        check("cmd_addr", cmd_addr, a);
        check("cmd_wdata", cmd_wdata, d);
        cmd_ready = 1'b1;
        hs++;
        tick();
        cmd_ready = 1'b0;
        check("cmd_valid_low", cmd_valid, 0);
    endtask

    task automatic respond(input logic v, input logic ab, input logic [7:0] d);
        rsp_valid = v;
        rsp_abort = ab;
        rsp_data  = d;
        tick();
        rsp_valid = 1'b0;
        rsp_abort = 1'b0;
    endtask

    task automatic wait_done(output int waited);
        exp_t e;
        int n = 0;
        while (done === 2'b00 && n < 300) begin
            tick();
            n++;
        end
        waited = n;
        e = '0;
        if (sb.size() > 0) e = sb.pop_front();
        check("done", done, e.done);
        check("err", err, e.err);
        if (e.chk) check("rdata", rdata, e.rdata);
    endtask

    initial begin
        rst       = 1'b1;
        req       = 2'b00;
        we        = 2'b00;
        addr      = 12'h000;
        wdata     = 16'h0000;
        link_idle = 1'b1;
        cmd_ready = 1'b0;
        rsp_valid = 1'b0;
        rsp_abort = 1'b0;
        rsp_data  = 8'h00;
        tick();
        tick();
        check("reset_outs", outs, 0);
        rst = 1'b0;

        // Write from requester 0, minimum latency
        set_fields(0, 1'b1, 6'h16, 8'hFF);
        req = 2'b01;
        t0 = cyc;
        push(2'b01, 1'b0, 1'b1, 8'h00);
        wait_gnt(2'b01, 1'b1);
        check("gnt_cycle", cyc - t0, 1);
        do_cmd(1'b1, 6'h16, 8'hFF);
        respond(1'b1, 1'b0, 8'h5A);
        wait_done(w);
        check("latency", cyc - t0, 4);

        // Read from requester 1; requester 0 pulses a request while busy
        set_fields(1, 1'b0, 6'h00, 8'h77);
        req = 2'b10;
        push(2'b10, 1'b0, 1'b1, 8'h24);
        wait_gnt(2'b10, 1'b1);
        set_fields(0, 1'b1, 6'h3C, 8'hAA);
        req[0] = 1'b1;
        do_cmd(1'b0, 6'h00, 8'h77);
        req[0] = 1'b0;
        respond(1'b1, 1'b0, 8'h24);
        wait_done(w);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("no_gnt_dropped", gnt, 0);
        end
        respond(1'b1, 1'b1, 8'hE7);
        check("idle_rsp_done", done, 0);
        check("idle_rsp_rdata", rdata, 8'h24);

        // Round robin with both requesters held high from reset
        rst = 1'b1;
        tick();
        rst = 1'b0;
        set_fields(0, 1'b1, 6'h01, 8'h11);
        set_fields(1, 1'b0, 6'h02, 8'h22);
        req = 2'b11;
        for (int i = 0; i < 4; i++) begin
            logic [1:0] g;
            g = (i % 2 == 0) ? 2'b01 : 2'b10;
            push(g, 1'b0, 1'b1, (g == 2'b01) ? 8'h00 : 8'(8'h30 + i));
            wait_gnt(g, 1'b0);
            if (g == 2'b01) do_cmd(1'b1, 6'h01, 8'h11);
            else do_cmd(1'b0, 6'h02, 8'h22);
            respond(1'b1, 1'b0, 8'(8'h30 + i));
            wait_done(w);
        end
        req = 2'b00;

        // Abort three times: two retries, then error
        set_fields(0, 1'b1, 6'h2A, 8'hC3);
        req = 2'b01;
        hs0 = hs;
        push(2'b01, 1'b1, 1'b0, 8'h00);
        wait_gnt(2'b01, 1'b1);
        for (int i = 0; i < 3; i++) begin
            do_cmd(1'b1, 6'h2A, 8'hC3);
            respond(1'b0, 1'b1, 8'h00);
        end
        wait_done(w);
        check("abort_handshakes", hs - hs0, 3);
        check("abort_done_wait", w, 0);

        // Response and abort together: success without retry
        set_fields(1, 1'b0, 6'h3F, 8'h00);
        req = 2'b10;
        hs0 = hs;
        push(2'b10, 1'b0, 1'b1, 8'h99);
        wait_gnt(2'b10, 1'b1);
        do_cmd(1'b0, 6'h3F, 8'h00);
        respond(1'b1, 1'b1, 8'h99);
        wait_done(w);
        check("both_done_wait", w, 0);
        check("both_handshakes", hs - hs0, 1);

        // No response: timeout 200 cycles after entering WAIT_RSP
        set_fields(0, 1'b0, 6'h05, 8'h00);
        req = 2'b01;
        push(2'b01, 1'b1, 1'b0, 8'h00);
        wait_gnt(2'b01, 1'b1);
        do_cmd(1'b0, 6'h05, 8'h00);
        t0 = cyc;
        wait_done(w);
        check("timeout_cycles", cyc - t0, 200);

        // Link busy holds off the grant; later deassertion is harmless
        link_idle = 1'b0;
        set_fields(0, 1'b1, 6'h10, 8'h42);
        req = 2'b01;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("link_busy_gnt", gnt, 0);
        end
        link_idle = 1'b1;
        push(2'b01, 1'b0, 1'b1, 8'h00);
        wait_gnt(2'b01, 1'b1);
        link_idle = 1'b0;
        do_cmd(1'b1, 6'h10, 8'h42);
        respond(1'b1, 1'b0, 8'h00);
        wait_done(w);
        link_idle = 1'b1;

        // Reset while waiting for the response
        set_fields(1, 1'b1, 6'h33, 8'h5C);
        req = 2'b10;
        wait_gnt(2'b10, 1'b1);
        do_cmd(1'b1, 6'h33, 8'h5C);
        rst = 1'b1;
        tick();
        check("midreset_outs", outs, 0);
        rst = 1'b0;
        rsp_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            rsp_valid = 1'b0;
            check("midreset_no_done", done, 0);
        end
        check("sb_left", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
